mem_responder: RTL and testbench

//  Memory-side responder for the CPU's MFA/MFC memory handshake. Serves word and

---
 rtl/mem_responder_if.sv | 22 ++
 rtl/mem_responder.sv | 115 +++++++++++
 tb/tb_mem_responder.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - MFA/MFC memory handshake bundle between CPU and memory responder
interface mem_responder_if #(
    parameter int ADDR_W = 8
);
    logic              MFA;
    logic              READ_WRITE;
    logic              WORD_BYTE;
    logic [ADDR_W-1:0] Address;
    logic [31:0]       DataIn;
    logic [31:0]       DataOut;
    logic              MFC;

    modport master (
        output MFA, READ_WRITE, WORD_BYTE, Address, DataIn,
        input  DataOut, MFC
    );

    modport slave (
        input  MFA, READ_WRITE, WORD_BYTE, Address, DataIn,
        output DataOut, MFC
    );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - byte-addressed big-endian RAM answering MFA with MFC after a programmable wait
module mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic           Clk,
    input  logic           Reset,
    mem_responder_if.slave bus
);
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              mfc_q;
    logic [31:0]       dout_q;
    logic              cap_rw;
    logic              cap_wb;
    logic [ADDR_W-1:0] cap_addr;
    logic [31:0]       cap_data;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wa0, wa1, wa2, wa3;
    logic [31:0]       rd_data;
    logic              access_now;
    logic              mem_we;

    // Word lanes never cross the aligned boundary, so no address arithmetic is needed.
    assign wa0 = {cap_addr[ADDR_W-1:2], 2'b00};
    assign wa1 = {cap_addr[ADDR_W-1:2], 2'b01};
    assign wa2 = {cap_addr[ADDR_W-1:2], 2'b10};
    assign wa3 = {cap_addr[ADDR_W-1:2], 2'b11};

    assign access_now = (state == BUSY) && (cnt == '0);
    assign mem_we     = access_now && !cap_rw && !Reset;

    always_comb begin
        rd_data = '0;
        if (cap_wb)
            rd_data = {mem[wa0], mem[wa1], mem[wa2], mem[wa3]};
        else
            rd_data = {24'b0, mem[cap_addr]};
    end

    // RAM has no reset: contents survive Reset by design.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            if (cap_wb) begin
                mem[wa0] <= cap_data[31:24];
                mem[wa1] <= cap_data[23:16];
                mem[wa2] <= cap_data[15:8];
                mem[wa3] <= cap_data[7:0];
            end else begin
                mem[cap_addr] <= cap_data[7:0];
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            mfc_q    <= 1'b0;
            dout_q   <= '0;
            cap_rw   <= 1'b0;
            cap_wb   <= 1'b0;
            cap_addr <= '0;
            cap_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    mfc_q <= 1'b0;
                    if (bus.MFA) begin
                        cap_rw   <= bus.READ_WRITE;
                        cap_wb   <= bus.WORD_BYTE;
                        cap_addr <= bus.Address;
                        cap_data <= bus.DataIn;
                        cnt      <= CNT_W'(WAIT_CYCLES);
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (cap_rw)
                            dout_q <= rd_data;
                        mfc_q <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // 4-phase: only a low MFA releases DONE, so a held MFA cannot retrigger.
                    if (!bus.MFA) begin
                        mfc_q <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    mfc_q <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.MFC     = mfc_q;
    assign bus.DataOut = dout_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized and directed checks of mem_responder against a byte-array model
module tb_mem_responder;
    logic Clk;
    logic Reset;

    mem_responder_if #(.ADDR_W(8)) bm ();
    mem_responder_if #(.ADDR_W(8)) b0 ();
    mem_responder_if #(.ADDR_W(8)) b5 ();

    mem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) u_main (.Clk(Clk), .Reset(Reset), .bus(bm));
    mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) u_w0   (.Clk(Clk), .Reset(Reset), .bus(b0));
    mem_responder #(.ADDR_W(8), .WAIT_CYCLES(5)) u_w5   (.Clk(Clk), .Reset(Reset), .bus(b5));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;

    logic [7:0]  mm [256];
    logic [31:0] m_dout;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [7:0] a);
        logic [7:0] b;
        b = a & 8'hFC;
        return {mm[b], mm[b + 8'd1], mm[b + 8'd2], mm[b + 8'd3]};
    endfunction

    task automatic model_op(input logic rw, input logic wb, input logic [7:0] a, input logic [31:0] d);
        logic [7:0] b;
        b = a & 8'hFC;
        if (rw) begin
            m_dout = wb ? model_word(a) : {24'b0, mm[a]};
        end else if (wb) begin
            mm[b]         = d[31:24];
            mm[b + 8'd1]  = d[23:16];
            mm[b + 8'd2]  = d[15:8];
            mm[b + 8'd3]  = d[7:0];
        end else begin
            mm[a] = d[7:0];
        end
    endtask

    task automatic access(input logic rw, input logic wb, input logic [7:0] a, input logic [31:0] d);
        int n;
        @(negedge Clk);
        bm.READ_WRITE = rw; bm.WORD_BYTE = wb; bm.Address = a; bm.DataIn = d; bm.MFA = 1'b1;
        @(posedge Clk);
        n = 0;
        while (n < 40) begin
            @(posedge Clk); #1; n++;
            if (bm.MFC) break;
        end
        model_op(rw, wb, a, d);
        chk("latency_w2", 32'(n), 32'd3);
        chk("dataout", bm.DataOut, m_dout);
        @(negedge Clk);
        bm.MFA = 1'b0;
        @(posedge Clk); #1;
        chk("mfc_fall", {31'b0, bm.MFC}, 32'd0);
    endtask

    task automatic aux_access(input logic rw, input logic [7:0] a, input logic [31:0] d);
        int r0, r5;
        @(negedge Clk);
        b0.READ_WRITE = rw; b0.WORD_BYTE = 1'b1; b0.Address = a; b0.DataIn = d; b0.MFA = 1'b1;
        b5.READ_WRITE = rw; b5.WORD_BYTE = 1'b1; b5.Address = a; b5.DataIn = d; b5.MFA = 1'b1;
        @(posedge Clk);
        r0 = -1; r5 = -1;
        for (int n = 1; n <= 10; n++) begin
            @(posedge Clk); #1;
            if (b0.MFC && r0 < 0) r0 = n;
            if (b5.MFC && r5 < 0) r5 = n;
        end
        chk("latency_w0", 32'(r0), 32'd1);
        chk("latency_w5", 32'(r5), 32'd6);
        chk("held_w0", {31'b0, b0.MFC}, 32'd1);
        chk("held_w5", {31'b0, b5.MFC}, 32'd1);
        if (rw) begin
            chk("aux_rd_w0", b0.DataOut, d);
            chk("aux_rd_w5", b5.DataOut, d);
        end
        @(negedge Clk);
        b0.MFA = 1'b0; b5.MFA = 1'b0;
        @(posedge Clk); #1;
        chk("fall_w0", {31'b0, b0.MFC}, 32'd0);
        chk("fall_w5", {31'b0, b5.MFC}, 32'd0);
    endtask

    initial begin
        logic [31:0] d, w;
        logic [7:0]  a;
        int n, rise, highs;

        bm.MFA = 1'b0; bm.READ_WRITE = 1'b0; bm.WORD_BYTE = 1'b0; bm.Address = '0; bm.DataIn = '0;
        b0.MFA = 1'b0; b0.READ_WRITE = 1'b0; b0.WORD_BYTE = 1'b0; b0.Address = '0; b0.DataIn = '0;
        b5.MFA = 1'b0; b5.READ_WRITE = 1'b0; b5.WORD_BYTE = 1'b0; b5.Address = '0; b5.DataIn = '0;
        m_dout = '0;
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        chk("reset_mfc", {31'b0, bm.MFC}, 32'd0);
        chk("reset_dout", bm.DataOut, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;

        // Fill the whole RAM so every later read has a known model value.
        for (int i = 0; i < 64; i++) access(1'b0, 1'b1, 8'(i * 4), $urandom);

        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom);
            access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom);
        end

        access(1'b0, 1'b1, 8'h10, 32'hDEADBEEF);
        access(1'b1, 1'b1, 8'h10, 32'h0);
        chk("word_rt", bm.DataOut, 32'hDEADBEEF);
        access(1'b1, 1'b0, 8'h10, 32'h0); chk("byte10", bm.DataOut, 32'h000000DE);
        access(1'b1, 1'b0, 8'h11, 32'h0); chk("byte11", bm.DataOut, 32'h000000AD);
        access(1'b1, 1'b0, 8'h12, 32'h0); chk("byte12", bm.DataOut, 32'h000000BE);
        access(1'b1, 1'b0, 8'h13, 32'h0); chk("byte13", bm.DataOut, 32'h000000EF);

        access(1'b0, 1'b0, 8'h12, 32'hFFFFFF5A);
        access(1'b1, 1'b1, 8'h11, 32'h0);
        chk("byte_merge", bm.DataOut, 32'hDEAD5AEF);

        // Reset while DONE with MFA still high: outputs clear asynchronously.
        @(negedge Clk);
        bm.READ_WRITE = 1'b1; bm.WORD_BYTE = 1'b1; bm.Address = 8'h10; bm.MFA = 1'b1;
        n = 0;
        while (n < 20 && !bm.MFC) begin @(posedge Clk); #1; n++; end
        chk("pre_reset_mfc", {31'b0, bm.MFC}, 32'd1);
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        chk("async_rst_mfc", {31'b0, bm.MFC}, 32'd0);
        chk("async_rst_dout", bm.DataOut, 32'd0);
        bm.MFA = 1'b0;
        m_dout = '0;
        @(negedge Clk);
        Reset = 1'b0;
        access(1'b1, 1'b1, 8'h10, 32'h0);

        aux_access(1'b0, 8'h44, 32'hCAFEF00D);
        aux_access(1'b1, 8'h44, 32'hCAFEF00D);

        // Write with MFA held 20 cycles and DataIn churning: only the captured value may land.
        a = 8'h30;
        d = $urandom;
        @(negedge Clk);
        bm.READ_WRITE = 1'b0; bm.WORD_BYTE = 1'b1; bm.Address = a; bm.DataIn = d; bm.MFA = 1'b1;
        @(posedge Clk);
        rise = -1; highs = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge Clk);
            bm.DataIn = $urandom;
            @(posedge Clk); #1;
            if (bm.MFC && rise < 0) rise = k;
            if (bm.MFC) highs++;
        end
        chk("hold_rise", 32'(rise), 32'd3);
        chk("hold_high_cycles", 32'(highs), 32'd18);
        model_op(1'b0, 1'b1, a, d);
        @(negedge Clk);
        bm.MFA = 1'b0;
        @(posedge Clk); #1;
        chk("hold_fall", {31'b0, bm.MFC}, 32'd0);
        access(1'b1, 1'b1, a, 32'h0);
        chk("hold_single_write", bm.DataOut, d);

        // MFA dropped in BUSY with inputs scrambled: one-cycle MFC pulse, captured write commits.
        a = 8'h54;
        d = $urandom;
        @(negedge Clk);
        bm.READ_WRITE = 1'b0; bm.WORD_BYTE = 1'b1; bm.Address = a; bm.DataIn = d; bm.MFA = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        bm.MFA = 1'b0; bm.Address = ~a; bm.DataIn = ~d; bm.READ_WRITE = 1'b1;
        rise = -1; highs = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge Clk); #1;
            if (bm.MFC && rise < 0) rise = k;
            if (bm.MFC) highs++;
        end
        chk("drop_rise", 32'(rise), 32'd3);
        chk("drop_pulse_len", 32'(highs), 32'd1);
        model_op(1'b0, 1'b1, a, d);
        access(1'b1, 1'b1, a, 32'h0);
        chk("drop_committed", bm.DataOut, d);
        access(1'b1, 1'b1, ~a, 32'h0);

        // Reset pulsed in BUSY of a write: nothing lands, MFC never rises.
        w = model_word(8'h20);
        @(negedge Clk);
        bm.READ_WRITE = 1'b0; bm.WORD_BYTE = 1'b1; bm.Address = 8'h20; bm.DataIn = 32'h11223344; bm.MFA = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        bm.MFA = 1'b0;
        #1;
        chk("rst_busy_mfc", {31'b0, bm.MFC}, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        m_dout = '0;
        highs = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge Clk); #1;
            if (bm.MFC) highs++;
        end
        chk("rst_busy_no_mfc", 32'(highs), 32'd0);
        access(1'b1, 1'b1, 8'h20, 32'h0);
        chk("rst_busy_mem_kept", bm.DataOut, w);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
